// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage: write-back stage of an in-order pipeline.
//
// Accepts one retiring instruction at a time. A non-load goes to the
// write-back cycle right away. A load waits for the data memory response,
// then extends the returned data according to funct3. The stage drives the
// register file write port and counts write-back cycles.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   in_valid       upstream presents a retiring instruction
//   in_ready       stage can accept (low only while waiting for load data)
//   in_rd          destination register
//   in_reg_write   instruction writes a register
//   in_mem_to_reg  instruction is a load
//   in_funct3      load size/sign code
//   in_alu_result  result for non-load instructions
//   mem_rvalid     data memory read data valid
//   mem_rdata      data memory read data, LSB-aligned
//   flush          synchronous kill of any held instruction
//   RegWrite       register file write enable
//   wa             register file write address
//   wd             register file write data
//   retire_cnt     number of write-back cycles since reset (wraps)
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] in_rd,
  input  logic                     in_reg_write,
  input  logic                     in_mem_to_reg,
  input  logic [2:0]               in_funct3,
  input  logic [DATA_WIDTH-1:0]    in_alu_result,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     flush,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0]    wd,
  output logic [31:0]              retire_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    WAIT  = 2'b01,
    WB    = 2'b10
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  state_t                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic                     regwrite_q, regwrite_d;
  logic                     rw_q, rw_d;
  logic [2:0]               f3_q, f3_d;
  logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0]    wd_q, wd_d;
  logic [31:0]              cnt_q, cnt_d;

  // Extend LSB-aligned load data. funct3[1:0] selects the size (byte, half,
  // word, full), funct3[2] selects zero-extension. "upper" marks the bits
  // above the loaded field; they are filled with the sign bit or zero.
  function automatic logic [DATA_WIDTH-1:0] load_ext(
    input logic [DATA_WIDTH-1:0] d,
    input logic [2:0]            f3
  );
    logic [DATA_WIDTH-1:0] upper;
    logic                  sb;
    upper = '0;
    sb    = 1'b0;
    case (f3[1:0])
      2'b00: begin upper = ONES << 8;  sb = d[7];  end
      2'b01: begin upper = ONES << 16; sb = d[15]; end
      2'b10: begin upper = ONES << 32; sb = d[31]; end
      default: begin upper = '0; sb = 1'b0; end
    endcase
    return (d & ~upper) | ((sb && !f3[2]) ? upper : '0);
  endfunction

  // Next-state logic. EMPTY and WB both accept; WAIT only listens to memory.
  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    rw_d    = rw_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;

    if (flush) begin
      // Kill whatever is held or offered; a WB in progress already wrote.
      state_d = EMPTY;
    end else begin
      case (state_q)
        WAIT: begin
          if (mem_rvalid) begin
            wd_d    = load_ext(mem_rdata, f3_q);
            state_d = WB;
          end
        end
        default: begin
          // EMPTY or WB: mem_rvalid is ignored here, even on a load accept.
          state_d = EMPTY;
          if (in_valid) begin
            wa_d = in_rd;
            rw_d = in_reg_write;
            if (in_mem_to_reg) begin
              f3_d    = in_funct3;
              state_d = WAIT;
            end else begin
              wd_d    = in_alu_result;
              state_d = WB;
            end
          end
        end
      endcase
    end

    // Outputs are registered, so they are decided on entry to the next state.
    if (state_d == WB) begin
      cnt_d = cnt_q + 32'd1;
    end
    regwrite_d = (state_d == WB) && rw_d && (wa_d != '0);
    ready_d    = (state_d != WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      ready_q    <= 1'b1;
      regwrite_q <= 1'b0;
      rw_q       <= 1'b0;
      f3_q       <= 3'b000;
      wa_q       <= '0;
      wd_q       <= '0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      regwrite_q <= regwrite_d;
      rw_q       <= rw_d;
      f3_q       <= f3_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = ready_q;
  assign RegWrite   = regwrite_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [2:0]  in_funct3;
  logic [63:0] in_alu_result;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        flush;
  logic        RegWrite;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic [31:0] retire_cnt;

  wb_stage #(.DATA_WIDTH(64), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
    .RegWrite(RegWrite), .wa(wa), .wd(wd), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [31:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] exp_cnt  = 32'd0;
  logic [31:0] prev_cnt = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference load extension.
  function automatic logic [63:0] ext_model(input logic [2:0] f3, input logic [63:0] d);
    case (f3)
      3'd0: return {{56{d[7]}},  d[7:0]};
      3'd1: return {{48{d[15]}}, d[15:0]};
      3'd2: return {{32{d[31]}}, d[31:0]};
      3'd4: return {56'h0, d[7:0]};
      3'd5: return {48'h0, d[15:0]};
      3'd6: return {32'h0, d[31:0]};
      default: return d;
    endcase
  endfunction

  // Record a write-back expected in the cycle after the current one.
  function automatic void push_exp(input logic rw, input logic [4:0] rd, input logic [63:0] d);
    exp_t e;
    exp_cnt = exp_cnt + 32'd1;
    e.rw  = rw && (rd != 5'd0);
    e.wa  = rd;
    e.wd  = d;
    e.cnt = exp_cnt;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a write-back cycle shows up as retire_cnt advancing by one.
  always @(negedge clk) begin
    if (rst) begin
      prev_cnt = 32'd0;
    end else begin
      if (retire_cnt === prev_cnt + 32'd1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_wb cyc=%0d got wa=%0d wd=%h cnt=%0d, none expected", cyc, wa, wd, retire_cnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (RegWrite !== e.rw || wa !== e.wa || wd !== e.wd || retire_cnt !== e.cnt || cyc != e.cyc) begin
            failures++;
            $display("FAIL wb_entry got rw=%b wa=%0d wd=%h cnt=%0d cyc=%0d exp rw=%b wa=%0d wd=%h cnt=%0d cyc=%0d",
                     RegWrite, wa, wd, retire_cnt, cyc, e.rw, e.wa, e.wd, e.cnt, e.cyc);
          end
        end
      end else begin
        checks++;
        if (RegWrite !== 1'b0) begin
          failures++;
          $display("FAIL write_outside_wb cyc=%0d got RegWrite=%b exp 0", cyc, RegWrite);
        end
        if (retire_cnt !== prev_cnt && retire_cnt !== 32'd0) begin
          failures++;
          $display("FAIL cnt_jump cyc=%0d got %0d from %0d", cyc, retire_cnt, prev_cnt);
        end
      end
      prev_cnt = retire_cnt;
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0; in_mem_to_reg = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    in_rd = '0; in_reg_write = 1'b0; in_funct3 = '0; in_alu_result = '0; mem_rdata = '0;
    #3;
    checks++;
    if (RegWrite !== 1'b0 || wa !== 5'd0 || wd !== 64'd0 || retire_cnt !== 32'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got rw=%b wa=%0d wd=%h cnt=%0d rdy=%b exp 0/0/0/0/1", RegWrite, wa, wd, retire_cnt, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 32'd0;
    step();
  endtask

  task automatic test_nonload();
    in_valid = 1'b1; in_mem_to_reg = 1'b0; in_rd = 5'd5; in_reg_write = 1'b1; in_alu_result = 64'h1234;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL nonload_ready got %b exp 1", in_ready); end
    push_exp(1'b1, 5'd5, 64'h1234);
    step();
    in_valid = 1'b0;
    checks++;
    if (RegWrite !== 1'b1 || wa !== 5'd5 || wd !== 64'h1234 || retire_cnt !== 32'd1) begin
      failures++;
      $display("FAIL nonload_wb got rw=%b wa=%0d wd=%h cnt=%0d exp 1/5/1234/1", RegWrite, wa, wd, retire_cnt);
    end
    step();
    step();
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [63:0] rdata, input logic [63:0] exp_wd);
    in_valid = 1'b1; in_mem_to_reg = 1'b1; in_rd = 5'd3; in_reg_write = 1'b1; in_funct3 = f3;
    in_alu_result = {$urandom, $urandom};
    mem_rvalid = 1'b1; mem_rdata = ~rdata;  // must be ignored on the accept cycle
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL load_accept_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0; in_mem_to_reg = 1'b0; mem_rvalid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL load_wait_ready1 got %b exp 0", in_ready); end
    step();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL load_wait_ready2 got %b exp 0", in_ready); end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    push_exp(1'b1, 5'd3, exp_wd);
    step();
    mem_rvalid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || wd !== exp_wd) begin
      failures++;
      $display("FAIL load_wb f3=%0d got rdy=%b wd=%h exp 1/%h", f3, in_ready, wd, exp_wd);
    end
    step();
  endtask

  task automatic test_x0();
    in_valid = 1'b1; in_mem_to_reg = 1'b0; in_rd = 5'd0; in_reg_write = 1'b1; in_alu_result = 64'hDEAD;
    push_exp(1'b1, 5'd0, 64'hDEAD);
    step();
    checks++;
    if (RegWrite !== 1'b0) begin failures++; $display("FAIL x0_write got %b exp 0", RegWrite); end
    // back-to-back instruction with reg_write=0
    in_rd = 5'd9; in_reg_write = 1'b0; in_alu_result = 64'h99;
    push_exp(1'b0, 5'd9, 64'h99);
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      in_valid = 1'b1; in_mem_to_reg = 1'b0; in_rd = 5'(i); in_reg_write = 1'b1; in_alu_result = d;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got %b exp 1", i, in_ready); end
      push_exp(1'b1, 5'(i), d);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || RegWrite !== 1'b1 || wa !== 5'd3) begin
      failures++;
      $display("FAIL b2b_last got rdy=%b rw=%b wa=%0d exp 1/1/3", in_ready, RegWrite, wa);
    end
    step();
    step();
  endtask

  task automatic test_flush();
    // flush while waiting for load data
    in_valid = 1'b1; in_mem_to_reg = 1'b1; in_rd = 5'd4; in_reg_write = 1'b1; in_funct3 = 3'd3;
    step();
    in_valid = 1'b0; in_mem_to_reg = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_wait_ready got %b exp 1", in_ready); end
    mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
    step();
    mem_rvalid = 1'b0;
    checks++;
    if (RegWrite !== 1'b0 || retire_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL flush_wait_nowb got rw=%b cnt=%0d exp 0/%0d", RegWrite, retire_cnt, exp_cnt);
    end
    step();
    // instruction offered together with flush is discarded
    in_valid = 1'b1; in_rd = 5'd8; in_reg_write = 1'b1; in_alu_result = 64'h88; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (RegWrite !== 1'b0 || retire_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL flush_discard got rw=%b cnt=%0d exp 0/%0d", RegWrite, retire_cnt, exp_cnt);
    end
    step();
    // flush during WB: write completes, the offered follower is dropped
    in_valid = 1'b1; in_rd = 5'd6; in_reg_write = 1'b1; in_alu_result = 64'h66;
    push_exp(1'b1, 5'd6, 64'h66);
    step();
    in_rd = 5'd7; in_alu_result = 64'h77; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (RegWrite !== 1'b0 || retire_cnt !== exp_cnt || wa !== 5'd6) begin
      failures++;
      $display("FAIL flush_in_wb got rw=%b cnt=%0d wa=%0d exp 0/%0d/6", RegWrite, retire_cnt, wa, exp_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    in_valid = 1'b1; in_mem_to_reg = 1'b0; in_rd = 5'd10; in_reg_write = 1'b1; in_alu_result = 64'hABCD;
    push_exp(1'b1, 5'd10, 64'hABCD);
    step();
    // load accepted in the WB cycle of the previous instruction
    in_mem_to_reg = 1'b1; in_rd = 5'd11; in_funct3 = 3'd3;
    step();
    in_valid = 1'b0; in_mem_to_reg = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || wa !== 5'd0 || wd !== 64'd0 || retire_cnt !== 32'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got rw=%b wa=%0d wd=%h cnt=%0d rdy=%b exp 0/0/0/0/1", RegWrite, wa, wd, retire_cnt, in_ready);
    end
    #1 rst = 1'b0;
    exp_cnt = 32'd0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got %b exp 1", in_ready); end
    mem_rvalid = 1'b1; mem_rdata = 64'h1111;
    step();
    mem_rvalid = 1'b0;
    checks++;
    if (RegWrite !== 1'b0 || retire_cnt !== 32'd0) begin
      failures++;
      $display("FAIL post_reset_nowb got rw=%b cnt=%0d exp 0/0", RegWrite, retire_cnt);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_load(3'd0, 64'h80, 64'hFFFFFFFFFFFFFF80);
    test_load(3'd4, 64'h80, 64'h80);
    for (int f = 0; f < 8; f++) begin
      logic [63:0] d;
      d = {$urandom, $urandom} | 64'h80008080;
      test_load(3'(f), d, ext_model(3'(f), d));
      d = {$urandom, $urandom} & ~64'h80008080;
      test_load(3'(f), d, ext_model(3'(f), d));
    end
    test_x0();
    test_back_to_back();
    test_flush();
    test_reset_mid_wait();
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_wb got %0d pending exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, the register data width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 5, the register address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents a retiring instruction.
REQ-006 in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready.
REQ-007 in_rd  input  ADDRESS_WIDTH  destination register.
REQ-008 in_reg_write  input  1  instruction writes a register.
REQ-009 in_mem_to_reg  input  1  instruction is a load; result comes from memory.
REQ-010 in_funct3  input  3  load size/sign code.
REQ-011 in_alu_result  input  DATA_WIDTH  ALU result for non-load instructions.
REQ-012 mem_rvalid  input  1  data memory read data valid.
REQ-013 mem_rdata  input  DATA_WIDTH  data memory read data, already LSB-aligned.
REQ-014 flush  input  1  synchronous kill of any held instruction.
REQ-015 RegWrite  output  1  register file write enable.
REQ-016 wa  output  ADDRESS_WIDTH  register file write address.
REQ-017 wd  output  DATA_WIDTH  register file write data.
REQ-018 retire_cnt  output  32  count of WB cycles since reset.

Function
REQ-019 The FSM SHALL have states EMPTY, WAIT (load awaiting memory), and WB (write-back cycle).
REQ-020 in_ready SHALL be 1 in EMPTY and WB, and 0 in WAIT.
REQ-021 On accept of a non-load (in_mem_to_reg=0), the block SHALL capture in_rd into wa, in_alu_result into wd, and in_reg_write, then go to WB next cycle.
REQ-022 On accept of a load, the block SHALL capture in_rd, in_reg_write and in_funct3, then go to WAIT.
REQ-023 In WAIT, the block SHALL hold until mem_rvalid=1, then load the extended mem_rdata into wd and go to WB next cycle.
REQ-024 mem_rvalid SHALL be ignored in EMPTY and WB, including the cycle in which a load is accepted.
REQ-025 Extension SHALL follow funct3: 000 sign-extend [7:0]; 001 sign-extend [15:0]; 010 sign-extend [31:0]; 011 full 64 bits; 100 zero-extend [7:0]; 101 zero-extend [15:0]; 110 zero-extend [31:0]; 111 full 64 bits.
REQ-026 RegWrite SHALL be 1 only in WB when captured reg_write=1 and wa!=0; a write to x0 SHALL never be asserted.
REQ-027 From WB, the block SHALL accept a new instruction in the same cycle (back-to-back); if none is accepted, it SHALL return to EMPTY.
REQ-028 Back-to-back non-loads SHALL produce consecutive WB cycles, giving one write per cycle.
REQ-029 wa and wd SHALL hold their last captured values outside WB.
REQ-030 retire_cnt SHALL increment by 1 in every WB cycle, whether or not RegWrite=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 Latency SHALL be as follows: a non-load accepted in cycle N is in WB in cycle N+1; a load whose mem_rvalid arrives in cycle M is in WB in cycle M+1.
REQ-032 flush SHALL have priority over accept and mem_rvalid, and SHALL force next state to EMPTY; an instruction offered in the flush cycle SHALL be discarded.
REQ-033 A WB cycle coinciding with flush SHALL still complete its write and count; flush affects only the following cycle.

Reset
REQ-034 While rst=1, the block SHALL set state to EMPTY, RegWrite=0, wa=0, wd=0, retire_cnt=0 and in_ready=1, independent of clk.
REQ-035 Reset asserted mid-WAIT or mid-WB SHALL drop the held instruction with no write.

Verification
REQ-036 Scenario 1: non-load rd=5, alu=0x1234, reg_write=1, accepted cycle N -> cycle N+1: RegWrite=1, wa=5, wd=0x1234, retire_cnt=1.
REQ-037 Scenario 2: load funct3=000, rd=3; mem_rvalid 2 cycles later with rdata=0x80 -> in_ready=0 while waiting; then WB with wd=0xFFFFFFFFFFFFFF80; repeating with funct3=100 gives wd=0x80.
REQ-038 Scenario 3: non-load with rd=0, reg_write=1 -> WB with RegWrite=0, retire_cnt increments.
REQ-039 Scenario 4: three back-to-back non-loads rd=1,2,3 -> three consecutive RegWrite=1 cycles, wa=1,2,3, in_ready stays 1.
REQ-040 Scenario 5: flush in WAIT, then mem_rvalid=1 -> no WB, state EMPTY, RegWrite=0.
REQ-041 Scenario 6: rst pulse asynchronously mid-WAIT -> outputs zero immediately; in_ready=1 after release.
